// File: rtl/mux_sched_pkg.sv
// Shared widths and FSM state type for the round-robin mux scheduler.
// Purely declarative: no logic, no latency, no flow control.
package mux_sched_pkg;

  localparam int N_CH  = 4;
  localparam int DIR_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

endpackage

// File: rtl/mux_rr_sched_if.sv
// Handshake bundle between four sources, the scheduler and the downstream sink.
// Wiring only: master is the scheduler side, slave is the source/sink side.
interface mux_rr_sched_if
  import mux_sched_pkg::*;
#(
  parameter int CNT_W = 3
);

  logic [N_CH-1:0]  valid_i;
  logic [N_CH-1:0]  ready_o;
  logic [DIR_W-1:0] direction_o;
  logic             valid_o;
  logic             ready_i;
  logic [CNT_W-1:0] burst_cnt_o;

  modport master (
    input  valid_i, ready_i,
    output ready_o, direction_o, valid_o, burst_cnt_o
  );

  modport slave (
    output valid_i, ready_i,
    input  ready_o, direction_o, valid_o, burst_cnt_o
  );

endinterface

// File: rtl/mux_top.sv
// 4:1 two-bit data mux steered by the scheduler's direction select.
// Combinational, zero latency; flow control lives in the scheduler.
module mux_top (
  input  logic [1:0] data0_i,
  input  logic [1:0] data1_i,
  input  logic [1:0] data2_i,
  input  logic [1:0] data3_i,
  input  logic [1:0] direction_i,
  output logic [1:0] data_o
);

  always_comb begin
    data_o = data0_i;
    case (direction_i)
      2'd0: data_o = data0_i;
      2'd1: data_o = data1_i;
      2'd2: data_o = data2_i;
      2'd3: data_o = data3_i;
      default: data_o = data0_i;
    endcase
  end

endmodule

// File: rtl/rr_picker.sv
// First set bit of req searching start, start+1, ... with wrap-around.
// Purely combinational, zero latency; no flow control.
module rr_picker
  import mux_sched_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [DIR_W-1:0] start,
  output logic             found,
  output logic [DIR_W-1:0] idx
);

  logic [DIR_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int i = 0; i < N_CH; i++) begin
      cand = start + DIR_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin arbiter for four valid/ready sources feeding mux_top, bursts capped at BURST_MAX.
// 1 cycle IDLE->first beat, back-to-back switches; ready_i low holds grant and count.
module mux_rr_sched
  import mux_sched_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mux_rr_sched_if.master bus
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_MAX - 1);

  sched_state_t     state, state_nxt;
  logic [DIR_W-1:0] dir, dir_nxt;
  logic [DIR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             granted;
  logic             cur_vld;
  logic             xfer;
  logic             rel;
  logic [DIR_W-1:0] g_next;
  logic [DIR_W-1:0] pick_start;
  logic             pick_found;
  logic [DIR_W-1:0] pick_idx;
  logic [N_CH-1:0]  ready_vec;

  assign granted = (state == GRANT);
  assign cur_vld = bus.valid_i[dir];
  assign xfer    = granted & cur_vld & bus.ready_i;
  assign rel     = granted & (~cur_vld | (xfer & (cnt == LAST_CNT)));
  assign g_next  = dir + DIR_W'(1);

  // One picker serves both the IDLE pick and the release re-pick.
  assign pick_start = granted ? g_next : ptr;

  rr_picker u_picker (
    .req   (bus.valid_i),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      dir   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          dir_nxt   = pick_idx;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_nxt = g_next;
          if (pick_found) begin
            dir_nxt = pick_idx;
            cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (xfer) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // valid_o depends only on state, dir and the granted valid, never on ready_i.
  always_comb begin
    ready_vec = '0;
    if (granted && bus.ready_i) ready_vec[dir] = 1'b1;
  end

  assign bus.valid_o     = granted & cur_vld;
  assign bus.ready_o     = ready_vec;
  assign bus.direction_o = dir;
  assign bus.burst_cnt_o = cnt;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed vector bench for mux_rr_sched driving mux_top, BURST_MAX=4.
module tb_mux_rr_sched;
  import mux_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] data_o;
  logic [1:0] src [4] = '{2'b11, 2'b10, 2'b01, 2'b00};

  mux_rr_sched_if #(.CNT_W(3)) bus ();

  mux_rr_sched #(.BURST_MAX(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  mux_top u_mux (
    .data0_i     (src[0]),
    .data1_i     (src[1]),
    .data2_i     (src[2]),
    .data3_i     (src[3]),
    .direction_i (bus.direction_o),
    .data_o      (data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic       r;
    logic [1:0] edir;
    logic       evld;
    logic [3:0] erdy;
    int         ecnt;
    logic       ccnt;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void add(input logic rs, input logic [3:0] v, input logic r,
                              input logic [1:0] edir, input logic evld,
                              input logic [3:0] erdy, input int ecnt, input logic ccnt);
    vec_t e;
    e.rst = rs; e.v = v; e.r = r; e.edir = edir; e.evld = evld;
    e.erdy = erdy; e.ecnt = ecnt; e.ccnt = ccnt;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.valid_i = 4'b0000;
    bus.ready_i = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.valid_i = 4'b1111;
    bus.ready_i = 1'b1;

    // Reset, then a single requester on channel 2 with an in-place re-grant and a drop.
    add(1, 4'b0100, 1, 0, 0, 4'b0000, 0, 1);
    for (int c = 0; c < 4; c++) add(0, 4'b0100, 1, 2, 1, 4'b0100, c, 1);
    add(0, 4'b0100, 1, 2, 1, 4'b0100, 0, 1);
    add(0, 4'b0000, 1, 2, 0, 4'b0100, 1, 1);
    add(0, 4'b0000, 1, 2, 0, 4'b0000, 0, 0);
    // Full contention: each channel held exactly four beats.
    add(1, 4'b1111, 1, 0, 0, 4'b0000, 0, 1);
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++)
        add(0, 4'b1111, 1, 2'(d), 1, 4'(1 << d), c, 1);
    add(0, 4'b1111, 1, 0, 1, 4'b0001, 0, 1);
    // Hand over to channel 1, backpressure at count 2, then sole-requester re-grant.
    add(0, 4'b0010, 1, 0, 0, 4'b0001, 1, 1);
    add(0, 4'b0010, 1, 1, 1, 4'b0010, 0, 1);
    add(0, 4'b0010, 1, 1, 1, 4'b0010, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 4'b0010, 0, 1, 1, 4'b0000, 2, 1);
    add(0, 4'b0010, 1, 1, 1, 4'b0010, 2, 1);
    add(0, 4'b0010, 1, 1, 1, 4'b0010, 3, 1);
    add(0, 4'b0010, 1, 1, 1, 4'b0010, 0, 1);
    // Channel 3 granted, drops after two beats, channel 0 follows without a bubble.
    add(0, 4'b1001, 1, 1, 0, 4'b0010, 1, 1);
    add(0, 4'b1001, 1, 3, 1, 4'b1000, 0, 1);
    add(0, 4'b1001, 1, 3, 1, 4'b1000, 1, 1);
    add(0, 4'b0001, 1, 3, 0, 4'b1000, 2, 1);
    add(0, 4'b0001, 1, 0, 1, 4'b0001, 0, 1);
    // Pointer priority: 1010 from ptr=0 grants 1 then 3.
    add(1, 4'b1010, 1, 0, 0, 4'b0000, 0, 1);
    for (int c = 0; c < 4; c++) add(0, 4'b1010, 1, 1, 1, 4'b0010, c, 1);
    add(0, 4'b1010, 1, 3, 1, 4'b1000, 0, 1);

    @(negedge clk);
    #1;
    chk("reset_dir", int'(bus.direction_o), 0);
    chk("reset_valid_o", int'(bus.valid_o), 0);
    chk("reset_ready_o", int'(bus.ready_o), 0);
    chk("reset_cnt", int'(bus.burst_cnt_o), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      bus.valid_i = vecs[i].v;
      bus.ready_i = vecs[i].r;
      #1;
      chk($sformatf("v%0d_dir", i), int'(bus.direction_o), int'(vecs[i].edir));
      chk($sformatf("v%0d_valid_o", i), int'(bus.valid_o), int'(vecs[i].evld));
      chk($sformatf("v%0d_ready_o", i), int'(bus.ready_o), int'(vecs[i].erdy));
      if (vecs[i].ccnt)
        chk($sformatf("v%0d_cnt", i), int'(bus.burst_cnt_o), vecs[i].ecnt);
      if (vecs[i].evld)
        chk($sformatf("v%0d_data", i), int'(data_o), int'(src[vecs[i].edir]));
    end

    // Asynchronous reset in the middle of a channel-2 burst.
    do_reset();
    @(negedge clk);
    bus.valid_i = 4'b0100;
    bus.ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_pre_dir", int'(bus.direction_o), 2);
    chk("mid_pre_cnt", int'(bus.burst_cnt_o), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid_o", int'(bus.valid_o), 0);
    chk("mid_rst_ready_o", int'(bus.ready_o), 0);
    chk("mid_rst_dir", int'(bus.direction_o), 0);
    chk("mid_rst_cnt", int'(bus.burst_cnt_o), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_idle_valid_o", int'(bus.valid_o), 0);
    @(negedge clk);
    #1;
    chk("post_rst_dir", int'(bus.direction_o), 2);
    chk("post_rst_valid_o", int'(bus.valid_o), 1);
    chk("post_rst_cnt", int'(bus.burst_cnt_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
